// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: FETCH/REGREAD/DATAMEM/REGWRITE with per-opcode phase skipping.
// Latency: strobes are a direct decode of the state register (0 extra cycles); ALU 3, BLQZ 2, ST 3+w, LD 4+w.
// Backpressure: DATAMEM stalls on mem_ack with a MEM_WAIT_MAX timeout into HALT; halt_req honoured at retire.
module multicycle_ctrl #(
   parameter int OP_W         = 3,
   parameter int OP_LD        = 5,
   parameter int OP_ST        = 6,
   parameter int OP_BLQZ      = 7,
   parameter int MEM_WAIT_MAX = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  opcode,
   input  logic             zero_flag,
   input  logic             mem_ack,
   input  logic             halt_req,
   output logic [2:0]       state_o,
   output logic             ir_load,
   output logic             rf_re,
   output logic             mem_req,
   output logic             mem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel_branch,
   output logic             mem_err,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FETCH    = 3'd1;
   localparam logic [2:0] S_REGREAD  = 3'd2;
   localparam logic [2:0] S_DATAMEM  = 3'd3;
   localparam logic [2:0] S_REGWRITE = 3'd4;
   localparam logic [2:0] S_HALT     = 3'd5;

   localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_WAIT_MAX - 1);
   localparam logic [OP_W-1:0] LD_C      = OP_W'(OP_LD);
   localparam logic [OP_W-1:0] ST_C      = OP_W'(OP_ST);
   localparam logic [OP_W-1:0] BR_C      = OP_W'(OP_BLQZ);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [WW-1:0] wait_cnt;
   logic          retire;
   logic          timeout;
   logic          is_ld;
   logic          is_st;
   logic          is_br;
   logic          active;

   assign is_ld   = (opcode == LD_C);
   assign is_st   = (opcode == ST_C);
   assign is_br   = (opcode == BR_C);
   assign state_o = state;
   assign active  = (state == S_FETCH) || (state == S_REGREAD) ||
                    (state == S_DATAMEM) || (state == S_REGWRITE);

   // Next-state and strobe decode; any retire is redirected to HALT when halt_req is up.
   always_comb begin
      next_state    = state;
      ir_load       = 1'b0;
      rf_re         = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel_branch = 1'b0;
      retire        = 1'b0;
      timeout       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_FETCH;
         end
         S_FETCH: begin
            ir_load    = 1'b1;
            next_state = S_REGREAD;
         end
         S_REGREAD: begin
            rf_re = 1'b1;
            if (is_ld || is_st) begin
               next_state = S_DATAMEM;
            end else if (is_br) begin
               pc_we         = 1'b1;
               pc_sel_branch = zero_flag;
               retire        = 1'b1;
            end else begin
               next_state = S_REGWRITE;
            end
         end
         S_DATAMEM: begin
            mem_req = 1'b1;
            mem_we  = is_st;
            if (mem_ack) begin
               if (is_st) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end else begin
                  next_state = S_REGWRITE;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               timeout    = 1'b1;
               next_state = S_HALT;
            end
         end
         S_REGWRITE: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
         end
         S_HALT: begin
            if (start) next_state = S_FETCH;
         end
         default: next_state = S_IDLE;
      endcase
      if (retire) next_state = halt_req ? S_HALT : S_FETCH;
   end

   // State register and the DATAMEM wait counter (zero on every entry to DATAMEM).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= (state == S_DATAMEM && next_state == S_DATAMEM) ? wait_cnt + 1'b1 : '0;
      end
   end

   // Sticky status: done mirrors HALT residency, mem_err holds until restart from HALT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done    <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         done <= (next_state == S_HALT);
         if (timeout)
            mem_err <= 1'b1;
         else if (state == S_HALT && start)
            mem_err <= 1'b0;
      end
   end

   // Saturating perf counters; they survive HALT and are cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (active && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
         if (pc_we && instr_cnt != CNT_MAX)  instr_cnt <= instr_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table through a scoreboard queue,
// plus hand sequences for async reset mid-DATAMEM and counter saturation (CNT_W=4 copy).
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  opcode;
   logic        zero_flag;
   logic        mem_ack;
   logic        halt_req;

   logic [2:0]  state_o;
   logic        ir_load, rf_re, mem_req, mem_we, rf_we, pc_we, pc_sel_branch, mem_err, done;
   logic [15:0] cycle_cnt, instr_cnt;

   logic [2:0]  b_state_o;
   logic        b_ir_load, b_rf_re, b_mem_req, b_mem_we, b_rf_we, b_pc_we, b_pc_sel_branch;
   logic        b_mem_err, b_done;
   logic [3:0]  b_cycle_cnt, b_instr_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero_flag(zero_flag),
      .mem_ack(mem_ack), .halt_req(halt_req), .state_o(state_o), .ir_load(ir_load),
      .rf_re(rf_re), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .pc_we(pc_we),
      .pc_sel_branch(pc_sel_branch), .mem_err(mem_err), .done(done),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   multicycle_ctrl #(.CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .zero_flag(zero_flag),
      .mem_ack(mem_ack), .halt_req(halt_req), .state_o(b_state_o), .ir_load(b_ir_load),
      .rf_re(b_rf_re), .mem_req(b_mem_req), .mem_we(b_mem_we), .rf_we(b_rf_we), .pc_we(b_pc_we),
      .pc_sel_branch(b_pc_sel_branch), .mem_err(b_mem_err), .done(b_done),
      .cycle_cnt(b_cycle_cnt), .instr_cnt(b_instr_cnt)
   );

   // Outputs bundle: {ir_load, rf_re, mem_req, mem_we, rf_we, pc_we, pc_sel_branch, mem_err, done}
   typedef struct {
      logic       st;
      logic [2:0] op;
      logic       zf;
      logic       ack;
      logic       hr;
      logic [2:0] es;
      logic [8:0] eo;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   task automatic add(input logic st, input logic [2:0] op, input logic zf, input logic ack,
                      input logic hr, input logic [2:0] es, input logic [8:0] eo);
      vec_t v;
      v.st = st; v.op = op; v.zf = zf; v.ack = ack; v.hr = hr; v.es = es; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic [8:0] act;
      int exp_cyc;
      int exp_ins;

      reset = 1'b1; start = 1'b0; opcode = 3'd0; zero_flag = 1'b0; mem_ack = 1'b0; halt_req = 1'b0;

      // idle / ADD (op 0)
      add(0, 0, 0, 0, 0, 3'd0, 9'b000000000);
      add(1, 0, 0, 0, 0, 3'd0, 9'b000000000);
      add(0, 0, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 0, 0, 0, 0, 3'd2, 9'b010000000);
      add(0, 0, 0, 0, 0, 3'd4, 9'b000011000);
      // LD, ack on third DATAMEM cycle
      add(0, 5, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 5, 0, 0, 0, 3'd2, 9'b010000000);
      add(0, 5, 0, 0, 0, 3'd3, 9'b001000000);
      add(0, 5, 0, 0, 0, 3'd3, 9'b001000000);
      add(0, 5, 0, 1, 0, 3'd3, 9'b001000000);
      add(0, 5, 0, 0, 0, 3'd4, 9'b000011000);
      // ST, ack same cycle
      add(0, 6, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 6, 0, 0, 0, 3'd2, 9'b010000000);
      add(0, 6, 0, 1, 0, 3'd3, 9'b001101000);
      // BLQZ taken / not taken
      add(0, 7, 1, 0, 0, 3'd1, 9'b100000000);
      add(0, 7, 1, 0, 0, 3'd2, 9'b010001100);
      add(0, 7, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 7, 0, 0, 0, 3'd2, 9'b010001000);
      // halt_req/start outside retire ignored, then honoured at retire
      add(1, 0, 0, 0, 1, 3'd1, 9'b100000000);
      add(1, 0, 0, 0, 1, 3'd2, 9'b010000000);
      add(0, 0, 0, 0, 1, 3'd4, 9'b000011000);
      add(0, 0, 0, 0, 0, 3'd5, 9'b000000001);
      add(0, 0, 0, 0, 0, 3'd5, 9'b000000001);
      add(1, 5, 0, 0, 0, 3'd5, 9'b000000001);
      // LD timeout: 8 DATAMEM cycles, then HALT with mem_err
      add(0, 5, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 5, 0, 0, 0, 3'd2, 9'b010000000);
      for (int i = 0; i < 8; i++) add(0, 5, 0, 0, 0, 3'd3, 9'b001000000);
      add(0, 5, 0, 0, 0, 3'd5, 9'b000000011);
      add(1, 3, 0, 0, 0, 3'd5, 9'b000000011);
      // restart clears status; ALU op 3
      add(0, 3, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 3, 0, 0, 0, 3'd2, 9'b010000000);
      add(0, 3, 0, 0, 0, 3'd4, 9'b000011000);
      // ST retiring in DATAMEM with halt_req
      add(0, 6, 0, 0, 0, 3'd1, 9'b100000000);
      add(0, 6, 0, 0, 0, 3'd2, 9'b010000000);
      add(0, 6, 0, 1, 1, 3'd3, 9'b001101000);
      add(0, 6, 0, 0, 0, 3'd5, 9'b000000001);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_cyc = 0;
      exp_ins = 0;

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         v = tbl[i];
         start = v.st; opcode = v.op; zero_flag = v.zf; mem_ack = v.ack; halt_req = v.hr;
         sb.push_back(v);
         @(negedge clk);
         v = sb.pop_front();
         act = {ir_load, rf_re, mem_req, mem_we, rf_we, pc_we, pc_sel_branch, mem_err, done};
         nvec++;
         if (state_o !== v.es || act !== v.eo || cycle_cnt !== 16'(exp_cyc) || instr_cnt !== 16'(exp_ins)) begin
            nerr++;
            $display("FAIL vec%0d: state=%0d out=%b cyc=%0d ins=%0d, expected state=%0d out=%b cyc=%0d ins=%0d",
                     i, state_o, act, cycle_cnt, instr_cnt, v.es, v.eo, exp_cyc, exp_ins);
         end
         if (v.es >= 3'd1 && v.es <= 3'd4) exp_cyc++;
         if (v.eo[3]) exp_ins++;
      end

      // Async reset in the middle of DATAMEM
      @(posedge clk); #1 start = 1'b1; opcode = 3'd5; zero_flag = 1'b0; mem_ack = 1'b0; halt_req = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("dm_state_before_reset", 32'(state_o), 32'd3);
      chk("dm_mem_req_before_reset", 32'(mem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_state_async", 32'(state_o), 32'd0);
      chk("rst_mem_req_async", 32'(mem_req), 32'd0);
      chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
      chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Counter saturation: ADD loop, compare 16-bit and 4-bit copies
      @(posedge clk); #1 start = 1'b1; opcode = 3'd0;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("cyc_after20", 32'(cycle_cnt), 32'd20);
      chk("cyc4_sat_after20", 32'(b_cycle_cnt), 32'd15);
      chk("ins_after20", 32'(instr_cnt), 32'd6);
      chk("ins4_after20", 32'(b_instr_cnt), 32'd6);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("cyc_after50", 32'(cycle_cnt), 32'd50);
      chk("cyc4_hold15", 32'(b_cycle_cnt), 32'd15);
      chk("ins_after50", 32'(instr_cnt), 32'd16);
      chk("ins4_sat", 32'(b_instr_cnt), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
